// File: rtl/add_pkg.sv
// add_pkg: shared definitions for the add/parity pipeline.
//   add_mode_t : operation select carried on the 2-bit mode port
//   DEPTH_MIN  : smallest supported pipeline depth
//   DEPTH_MAX  : largest supported pipeline depth
package add_pkg;

  // Operation select. The reserved code behaves exactly like ADD_WRAP.
  typedef enum logic [1:0] {
    ADD_WRAP = 2'b00,
    ADD_SAT  = 2'b01,
    ADD_ACC  = 2'b10,
    ADD_RSVD = 2'b11
  } add_mode_t;

  localparam int DEPTH_MIN = 1;
  localparam int DEPTH_MAX = 4;

endpackage

// File: rtl/pipe_stage.sv
// pipe_stage: one valid-tagged register slice of an elastic pipeline.
//   clk, rst : clock, asynchronous active-high reset
//   i_valid  : upstream offers a payload
//   o_ready  : this slice can take the upstream payload this cycle
//   i_data   : upstream payload
//   o_valid  : this slice holds a payload
//   i_ready  : downstream takes the held payload this cycle
//   o_data   : held payload
module pipe_stage #(
  parameter int W = 9
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_valid,
  output logic         o_ready,
  input  logic [W-1:0] i_data,
  output logic         o_valid,
  input  logic         i_ready,
  output logic [W-1:0] o_data
);

  logic         r_valid;
  logic [W-1:0] r_data;
  logic         w_load;

  // The slice can take new data when empty or when its payload leaves this cycle.
  assign o_ready = ~r_valid | i_ready;
  assign w_load  = i_valid & o_ready;

  // Whenever the slice is free to change, its valid simply follows the upstream
  // offer, so an advancing payload with nothing behind it leaves the slice empty.
  // Data only changes on an actual load, which keeps it frozen while stalled.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid <= 1'b0;
      r_data  <= '0;
    end else begin
      if (o_ready) begin
        r_valid <= i_valid;
      end
      if (w_load) begin
        r_data <= i_data;
      end
    end
  end

  assign o_valid = r_valid;
  assign o_data  = r_data;

endmodule

// File: rtl/add_parity_pipe.sv
// add_parity_pipe: elastic adder pipeline with wrap / saturate / accumulate
// modes, carry-out and parity of the delivered result.
//   clk, rst   : clock, asynchronous active-high reset
//   in_valid   : operand beat offered
//   in_ready   : beat accepted this cycle when in_valid is also high
//   a, b       : operands (b unused in accumulate mode)
//   mode       : 00 wrap, 01 saturate, 10 accumulate, 11 behaves as wrap
//   acc_clr    : on an accepted beat, zero the accumulator before the add
//   out_valid  : result beat present
//   out_ready  : consumer takes the result this cycle
//   sum        : result (0 when no result is present)
//   carry      : carry-out of the unsaturated add (0 when no result)
//   parity     : XOR of all bits of sum
module add_parity_pipe
  import add_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [1:0]       mode,
  input  logic             acc_clr,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             carry,
  output logic             parity
);

  // Depth is held inside the supported range so an out-of-range override
  // still elaborates into a working pipeline.
  localparam int STAGES = (DEPTH < DEPTH_MIN) ? DEPTH_MIN :
                          (DEPTH > DEPTH_MAX) ? DEPTH_MAX : DEPTH;
  localparam int PW     = WIDTH + 1;

  add_mode_t        w_mode;
  logic [WIDTH-1:0] w_opA;
  logic [WIDTH-1:0] w_opB;
  logic [WIDTH:0]   w_full;
  logic [WIDTH-1:0] w_result;
  logic [PW-1:0]    w_headData;
  logic             w_headReady;
  logic             w_accept;
  logic             w_tailValid;
  logic [PW-1:0]    w_tailData;
  logic [WIDTH-1:0] r_acc;

  assign w_mode = add_mode_t'(mode);

  // Operand selection: accumulate mode adds a to the running total (or to zero
  // when acc_clr asks for a fresh start); every other mode adds a and b.
  always_comb begin
    w_opA = a;
    w_opB = b;
    if (w_mode == ADD_ACC) begin
      w_opA = acc_clr ? '0 : r_acc;
      w_opB = a;
    end
  end

  // The add is done one bit wider so the top bit is the carry in every mode.
  assign w_full     = {1'b0, w_opA} + {1'b0, w_opB};
  assign w_result   = (w_mode == ADD_SAT && w_full[WIDTH]) ? '1 : w_full[WIDTH-1:0];
  assign w_headData = {w_full[WIDTH], w_result};

  assign in_ready = w_headReady & ~rst;
  assign w_accept = in_valid & in_ready;

  // Accumulator tracks the wrapped sum of accepted accumulate beats; a cleared
  // non-accumulate beat still zeroes it, any other beat leaves it alone.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_acc <= '0;
    end else if (w_accept) begin
      if (w_mode == ADD_ACC) begin
        r_acc <= w_full[WIDTH-1:0];
      end else if (acc_clr) begin
        r_acc <= '0;
      end
    end
  end

  // Chain of slices. Each slice keeps its own handshake wires so the ready
  // path, which runs back from the output to the input, stays a plain chain.
  for (genvar g = 0; g < STAGES; g++) begin : g_stage
    logic          w_vIn;
    logic [PW-1:0] w_dIn;
    logic          w_rdyDn;
    logic          w_vld;
    logic          w_rdy;
    logic [PW-1:0] w_dat;

    if (g == 0) begin : g_head
      assign w_vIn = in_valid;
      assign w_dIn = w_headData;
    end else begin : g_link
      assign w_vIn = g_stage[g-1].w_vld;
      assign w_dIn = g_stage[g-1].w_dat;
    end

    if (g == STAGES - 1) begin : g_tail
      assign w_rdyDn = out_ready;
    end else begin : g_mid
      assign w_rdyDn = g_stage[g+1].w_rdy;
    end

    pipe_stage #(
      .W (PW)
    ) u_stage (
      .clk     (clk),
      .rst     (rst),
      .i_valid (w_vIn),
      .o_ready (w_rdy),
      .i_data  (w_dIn),
      .o_valid (w_vld),
      .i_ready (w_rdyDn),
      .o_data  (w_dat)
    );
  end

  assign w_headReady = g_stage[0].w_rdy;
  assign w_tailValid = g_stage[STAGES-1].w_vld;
  assign w_tailData  = g_stage[STAGES-1].w_dat;

  // Result fields are forced to zero whenever no beat is presented, and parity
  // is taken from the delivered (already saturated) sum.
  assign out_valid = w_tailValid;
  assign sum       = w_tailValid ? w_tailData[WIDTH-1:0] : '0;
  assign carry     = w_tailValid & w_tailData[WIDTH];
  assign parity    = ^sum;

endmodule
